// File: rtl/adc_spi_responder.sv
// adc_spi_responder: emulates the LTC2308 end of the joystick ADC serial link,
// returning programmable 12-bit channel values and capturing the 6-bit config word.
// Latency: SYNC_STAGES+1 clk edges from a CONVST/SCK pin change to the resulting update;
// busy covers CONVERT and SHIFT. The master paces the frame, so there is no backpressure.
// Ports:
//   clk, reset_n          : clock and synchronous active-low reset
//   ADC_CONVST/SCK/SDI    : asynchronous master pins, synchronised internally
//   ADC_SDO               : registered result bit, MSB first
//   chan_data             : eight 12-bit channel values, channel n at [12n+11:12n]
//   cfg_word, cfg_valid   : last committed config word and its one-cycle update pulse
//   busy, frame_err       : frame in progress, one-cycle abort pulse
module adc_spi_responder #(
   parameter int SYNC_STAGES = 2,
   parameter int CONV_CYCLES = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        ADC_CONVST,
   input  logic        ADC_SCK,
   input  logic        ADC_SDI,
   output logic        ADC_SDO,
   input  logic [95:0] chan_data,
   output logic [5:0]  cfg_word,
   output logic        cfg_valid,
   output logic        busy,
   output logic        frame_err
);

   localparam int CW = $clog2(CONV_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CONVERT = 2'd1,
      ST_SHIFT   = 2'd2
   } state_t;

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] convst_sync_q;
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] sdi_sync_q;
   logic                   convst_dly_q;
   logic                   sck_dly_q;
   logic [CW-1:0]          conv_cnt_q;
   logic [11:0]            data_q;
   logic [4:0]             cfg_shift_q;
   logic [2:0]             rx_cnt_q;
   logic [3:0]             tx_cnt_q;
   logic [2:0]             next_ch_q;
   logic                   sdo_q;
   logic [5:0]             cfg_word_q;
   logic                   cfg_valid_q;
   logic                   busy_q;
   logic                   frame_err_q;

   // Synchronised pin levels and their edges. The extra delay flop after the
   // last synchroniser stage gives the SYNC_STAGES+1 pin-to-action latency.
   logic       convst_s;
   logic       sck_s;
   logic       sdi_s;
   logic       convst_rise;
   logic       sck_rise;
   logic       sck_fall;
   logic [5:0] cfg_d;
   logic [6:0] sel_base;
   logic [11:0] chan_sel;

   assign convst_s    = convst_sync_q[SYNC_STAGES-1];
   assign sck_s       = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s       = sdi_sync_q[SYNC_STAGES-1];
   assign convst_rise = convst_s & ~convst_dly_q;
   assign sck_rise    = sck_s & ~sck_dly_q;
   assign sck_fall    = ~sck_s & sck_dly_q;

   // Config word as it would look after shifting in the current SDI bit.
   assign cfg_d    = {cfg_shift_q, sdi_s};
   assign sel_base = 7'(next_ch_q) * 7'd12;
   assign chan_sel = chan_data[sel_base +: 12];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         convst_sync_q <= '0;
         sck_sync_q    <= '0;
         sdi_sync_q    <= '0;
         convst_dly_q  <= 1'b0;
         sck_dly_q     <= 1'b0;
         conv_cnt_q    <= '0;
         data_q        <= '0;
         cfg_shift_q   <= '0;
         rx_cnt_q      <= '0;
         tx_cnt_q      <= '0;
         next_ch_q     <= '0;
         sdo_q         <= 1'b0;
         cfg_word_q    <= '0;
         cfg_valid_q   <= 1'b0;
         busy_q        <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         convst_sync_q <= {convst_sync_q[SYNC_STAGES-2:0], ADC_CONVST};
         sck_sync_q    <= {sck_sync_q[SYNC_STAGES-2:0], ADC_SCK};
         sdi_sync_q    <= {sdi_sync_q[SYNC_STAGES-2:0], ADC_SDI};
         convst_dly_q  <= convst_s;
         sck_dly_q     <= sck_s;
         cfg_valid_q   <= 1'b0;
         frame_err_q   <= 1'b0;

         if (convst_rise) begin
            // A CONVST rise always starts a fresh conversion; mid-frame it
            // also flags the abort and drops any partial config bits.
            if (state_q != ST_IDLE) frame_err_q <= 1'b1;
            data_q      <= chan_sel;
            conv_cnt_q  <= CW'(CONV_CYCLES);
            cfg_shift_q <= '0;
            rx_cnt_q    <= '0;
            tx_cnt_q    <= '0;
            sdo_q       <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_CONVERT;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  sdo_q <= 1'b0;
               end
               ST_CONVERT: begin
                  if (conv_cnt_q != '0) begin
                     conv_cnt_q <= conv_cnt_q - 1'b1;
                  end else if (!convst_s) begin
                     // Conversion done and CONVST released: present the MSB.
                     sdo_q   <= data_q[11];
                     state_q <= ST_SHIFT;
                  end
               end
               ST_SHIFT: begin
                  if (sck_rise) begin
                     if (rx_cnt_q < 3'd6) begin
                        cfg_shift_q <= cfg_d[4:0];
                        rx_cnt_q    <= rx_cnt_q + 1'b1;
                        if (rx_cnt_q == 3'd5) begin
                           cfg_word_q  <= cfg_d;
                           cfg_valid_q <= 1'b1;
                           // Single-ended selects {S1, S0, O/S}; differential keeps the channel.
                           if (cfg_d[5]) next_ch_q <= {cfg_d[3], cfg_d[2], cfg_d[4]};
                        end
                     end
                  end else if (sck_fall) begin
                     tx_cnt_q <= tx_cnt_q + 1'b1;
                     if (tx_cnt_q == 4'd11) begin
                        sdo_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end else begin
                        sdo_q  <= data_q[10];
                        data_q <= {data_q[10:0], 1'b0};
                     end
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  sdo_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign ADC_SDO   = sdo_q;
   assign cfg_word  = cfg_word_q;
   assign cfg_valid = cfg_valid_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

endmodule

// File: doc/adc_spi_responder.md
# adc_spi_responder

Synthesizable emulator of the LTC2308 side of the ADC serial link that the joystick stage masters (ADC_CONVST, ADC_SCK, ADC_SDI in, ADC_SDO out). It returns programmable 12-bit channel values so the joystick sequence checker can be exercised on the board or in simulation without the physical joystick. It sits in a loopback build between joystick_seq's ADC pins and a register bank that supplies channel values. All master-driven pins are treated as asynchronous, then synchronised and edge-detected in the `clk` domain.

## Interface
- SYNC_STAGES, 2, flip-flop depth of the input synchroniser on ADC_CONVST, ADC_SCK and ADC_SDI (minimum 2).
- CONV_CYCLES, 8, `clk` cycles of emulated conversion time after a detected CONVST rise.
- clk  in  1  sole clock; every register samples on its rising edge.
- reset_n  in  1  reset, synchronous and active-low.
- ADC_CONVST  in  1  conversion start from the master.
- ADC_SCK  in  1  serial clock from the master.
- ADC_SDI  in  1  config bits from the master, MSB first.
- ADC_SDO  out  1  result bits to the master, MSB first.
- chan_data  in  96  eight 12-bit channel values; channel n occupies [12n+11:12n].
- cfg_word  out  6  last received config word {S/D, O/S, S1, S0, UNI, SLP}.
- cfg_valid  out  1  one-cycle pulse when cfg_word updates.
- busy  out  1  high in CONVERT and SHIFT.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

## Operation
- Reset (reset_n low at a clk edge): state IDLE; ADC_SDO=0; cfg_word=0; cfg_valid=0; busy=0; frame_err=0; next_ch=0; synchroniser flops=0; bit counters=0.
- Edge detect: rise/fall are taken from the last two synchroniser stages.
- IDLE
  - On CONVST rise: latch chan_data[next_ch] into the 12-bit shift register.
  - Load the conversion counter with CONV_CYCLES and go to CONVERT.
- CONVERT
  - ADC_SDO is held at 0.
  - SCK edges are ignored.
  - The counter decrements once per cycle.
  - When the counter is 0 and synced CONVST is low, go to SHIFT with ADC_SDO = shift bit 11. If CONVST is still high, wait.
- SHIFT
  - Each SCK rise: if rx_count < 6, shift synced SDI into cfg_shift; rx_count++.
  - The rise that makes rx_count = 6 commits cfg_word:
    - cfg_valid pulses.
    - If S/D = 1, next_ch = {S1, S0, O/S}; otherwise next_ch is unchanged.
  - Each SCK fall: tx_count++.
    - If tx_count < 12, ADC_SDO = next lower bit.
    - The 12th fall drives ADC_SDO = 0 and returns to IDLE.
- Abort: a CONVST rise while in SHIFT or CONVERT pulses frame_err, discards partial config (cfg_word unchanged), clears the counters and restarts the IDLE rise action in the same cycle.
- Simultaneous SCK rise and fall are impossible by construction. A CONVST rise in the same cycle as an SCK edge: the abort wins.
- Fewer than 6 rises before the abort: next_ch is unchanged.
- Changing chan_data after the latch does not affect the frame in flight.

## Timing
- Pin-to-action latency: SYNC_STAGES+1 clk edges from an ADC_SCK/ADC_CONVST pin change to the resulting register update.
  - ADC_SDO is valid SYNC_STAGES+1 cycles after the SCK pin falls.
- Master requirement: SCK high and SCK low phases are each ≥ SYNC_STAGES+2 clk cycles. The master samples SDO on the SCK rise.
- Config pipeline: config received in frame N selects the channel converted in frame N+1. Frame 0 after reset returns channel 0.
- A conversion completes CONV_CYCLES+SYNC_STAGES+1 cycles after the CONVST pin rise, at the earliest.
- busy rises on the cycle of the IDLE→CONVERT transition and falls on the cycle of the 12th-fall transition to IDLE.

## Test plan
- Reset mid-SHIFT (after 5 SCK falls), then a new frame with SDI=0: ADC_SDO=0 and cfg_word=0 immediately after reset; the frame returns the channel 0 value.
- chan_data ch0=12'hA5C: after reset, CONVST pulse then 12 SCK cycles with SDI=6'b100010 → master reads 12'hA5C; cfg_valid pulses once; cfg_word=6'b100010; next_ch=0.
- Frame 1 sends SDI=6'b110110 (S/D=1, O/S=1, S1=0, S0=1): frame 2 returns ch3 (set to 12'h3F0) → reads 12'h3F0.
- Differential config 6'b000010 after selecting ch5 (12'h7FF): the next frame still returns 12'h7FF.
- CONVST re-asserted after 5 SCK rises: frame_err pulses once; cfg_word is unchanged; the restarted frame returns the full 12 bits correctly.
- CONVST held high for 20 cycles (CONV_CYCLES=8): SDO stays 0 and busy stays 1 until CONVST falls; SCK edges during CONVERT are ignored; the data read is unchanged.
